// File: rtl/count_ctrl_pkg.sv
// Shared types and constants for the counter enable controller.
package count_ctrl_pkg;

  localparam int unsigned PRESCALE_W_DEF = 8;
  localparam int unsigned BURST_W_DEF    = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic MODE_CONT  = 1'b0;
  localparam logic MODE_BURST = 1'b1;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running prescaler: counts 0..period while running, flags the terminal count.
module tick_prescaler #(
  parameter int unsigned PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  run,
  input  logic [PRESCALE_W-1:0] period,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] presc_q;
  logic [PRESCALE_W-1:0] presc_d;
  logic                  at_end;

  assign at_end = (presc_q == period);

  always_comb begin
    presc_d = presc_q;
    if (clear) begin
      presc_d = '0;
    end else if (run) begin
      presc_d = at_end ? '0 : presc_q + PRESCALE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  // Decoded from registers only, so enable has no input-to-output path.
  assign tick = run && at_end;

endmodule

// File: rtl/count_enable_ctrl.sv
// Enable-strobe generator for the 4-bit event counter: continuous or N-pulse
// burst runs at a programmable prescaled rate.
module count_enable_ctrl
  import count_ctrl_pkg::*;
#(
  parameter int unsigned PRESCALE_W = PRESCALE_W_DEF,
  parameter int unsigned BURST_W    = BURST_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  mode,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [BURST_W-1:0]    burst_len,
  output logic                  enable,
  output logic                  busy,
  output logic                  done,
  output logic [BURST_W-1:0]    pulse_cnt
);

  state_t                state_q;
  state_t                state_d;
  logic                  mode_q;
  logic                  mode_d;
  logic [PRESCALE_W-1:0] prescale_q;
  logic [PRESCALE_W-1:0] prescale_d;
  logic [BURST_W-1:0]    burst_len_q;
  logic [BURST_W-1:0]    burst_len_d;
  logic [BURST_W-1:0]    cnt_q;
  logic [BURST_W-1:0]    cnt_d;
  logic                  done_q;
  logic                  done_d;
  logic                  presc_clear_c;
  logic                  running_c;
  logic                  tick_c;
  logic                  last_pulse_c;

  assign running_c    = (state_q == RUN);
  assign last_pulse_c = (cnt_q == BURST_W'(burst_len_q - BURST_W'(1)));

  tick_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_presc (
    .clk    (clk),
    .reset  (reset),
    .clear  (presc_clear_c),
    .run    (running_c),
    .period (prescale_q),
    .tick   (tick_c)
  );

  // Next-state, config latch, pulse count and done-pulse decode.
  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    prescale_d    = prescale_q;
    burst_len_d   = burst_len_q;
    cnt_d         = cnt_q;
    done_d        = 1'b0;
    presc_clear_c = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start && !stop) begin
          mode_d      = mode;
          prescale_d  = prescale;
          burst_len_d = burst_len;
          cnt_d       = '0;
          if ((mode == MODE_BURST) && (burst_len == '0)) begin
            // Empty burst completes immediately without entering RUN.
            done_d = 1'b1;
          end else begin
            state_d       = RUN;
            presc_clear_c = 1'b1;
          end
        end
      end

      RUN: begin
        // The strobe in this cycle is always counted, even when stopping,
        // so pulse_cnt keeps tracking the downstream counter.
        if (tick_c) begin
          if ((mode_q == MODE_BURST) && last_pulse_c) begin
            cnt_d   = burst_len_q;
            state_d = IDLE;
            done_d  = !stop;
          end else begin
            cnt_d = cnt_q + BURST_W'(1);
          end
        end
        if (stop) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      mode_q      <= MODE_CONT;
      prescale_q  <= '0;
      burst_len_q <= '0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      prescale_q  <= prescale_d;
      burst_len_q <= burst_len_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
    end
  end

  assign enable    = tick_c;
  assign busy      = running_c;
  assign done      = done_q;
  assign pulse_cnt = cnt_q;

endmodule

// File: tb/tb_count_enable_ctrl.sv
// Self-checking bench for count_enable_ctrl: vector table, directed corner
// sequences and randomized traffic against a cycle-count reference model.
module tb_count_enable_ctrl;

  logic       clk;
  logic       reset;
  logic       start;
  logic       stop;
  logic       mode;
  logic [7:0] prescale;
  logic [3:0] burst_len;
  logic       enable;
  logic       busy;
  logic       done;
  logic [3:0] pulse_cnt;
  logic [3:0] down_q;

  int n_checks = 0;
  int n_fail   = 0;

  count_enable_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .mode      (mode),
    .prescale  (prescale),
    .burst_len (burst_len),
    .enable    (enable),
    .busy      (busy),
    .done      (done),
    .pulse_cnt (pulse_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the downstream 4-bit event counter.
  always @(posedge clk) begin
    if (reset) down_q <= 4'd0;
    else if (enable) down_q <= down_q + 4'd1;
  end

  typedef struct {
    logic       rst;
    logic       start;
    logic       stop;
    logic       mode;
    logic [7:0] presc;
    logic [3:0] len;
    logic       en;
    logic       busy;
    logic       done;
    logic [3:0] cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input int en, input int bsy, input int dn, input int cnt);
    check({tag, ".enable"}, int'(enable), en);
    check({tag, ".busy"}, int'(busy), bsy);
    check({tag, ".done"}, int'(done), dn);
    check({tag, ".pulse_cnt"}, int'(pulse_cnt), cnt);
  endtask

  task automatic add(input logic r, input logic s, input logic p, input logic m,
                     input logic [7:0] pr, input logic [3:0] l,
                     input logic e, input logic b, input logic d, input logic [3:0] c);
    vec_t v;
    v.rst = r; v.start = s; v.stop = p; v.mode = m; v.presc = pr; v.len = l;
    v.en = e; v.busy = b; v.done = d; v.cnt = c;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic r, input logic s, input logic p, input logic m,
                       input logic [7:0] pr, input logic [3:0] l);
    reset = r; start = s; stop = p; mode = m; prescale = pr; burst_len = l;
  endtask

  // Reference model state: run flag, cycles since run start, latched config.
  bit m_run;
  int m_t;
  bit m_mode;
  int m_p;
  int m_len;
  int m_cnt;
  bit m_done;

  initial begin
    bit exp_en;
    bit nd;

    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 4'd0);

    // Reset held three cycles, then released.
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_outs("reset", 0, 0, 0, 0);

    // Burst p=2 len=5 with ignored inputs, empty burst, start&&stop priority.
    add(0, 0, 0, 0, 8'd0, 4'd0,  0, 0, 0, 4'd0);
    add(0, 1, 0, 1, 8'd2, 4'd5,  0, 0, 0, 4'd0);
    add(0, 0, 0, 0, 8'd7, 4'd1,  0, 1, 0, 4'd0);
    add(0, 0, 0, 0, 8'd7, 4'd1,  0, 1, 0, 4'd0);
    add(0, 0, 0, 0, 8'd7, 4'd1,  1, 1, 0, 4'd0);
    add(0, 1, 0, 0, 8'd7, 4'd1,  0, 1, 0, 4'd1);
    add(0, 0, 0, 0, 8'd0, 4'd0,  0, 1, 0, 4'd1);
    add(0, 0, 0, 0, 8'd0, 4'd0,  1, 1, 0, 4'd1);
    add(0, 0, 0, 0, 8'd0, 4'd0,  0, 1, 0, 4'd2);
    add(0, 0, 0, 0, 8'd0, 4'd0,  0, 1, 0, 4'd2);
    add(0, 0, 0, 0, 8'd0, 4'd0,  1, 1, 0, 4'd2);
    add(0, 0, 0, 0, 8'd0, 4'd0,  0, 1, 0, 4'd3);
    add(0, 0, 0, 0, 8'd0, 4'd0,  0, 1, 0, 4'd3);
    add(0, 0, 0, 0, 8'd0, 4'd0,  1, 1, 0, 4'd3);
    add(0, 0, 0, 0, 8'd0, 4'd0,  0, 1, 0, 4'd4);
    add(0, 0, 0, 0, 8'd0, 4'd0,  0, 1, 0, 4'd4);
    add(0, 0, 0, 0, 8'd0, 4'd0,  1, 1, 0, 4'd4);
    add(0, 0, 0, 0, 8'd0, 4'd0,  0, 0, 1, 4'd5);
    add(0, 1, 0, 1, 8'd0, 4'd0,  0, 0, 0, 4'd5);
    add(0, 0, 0, 0, 8'd0, 4'd0,  0, 0, 1, 4'd0);
    add(0, 1, 1, 0, 8'd0, 4'd0,  0, 0, 0, 4'd0);
    add(0, 0, 0, 0, 8'd0, 4'd0,  0, 0, 0, 4'd0);
    add(0, 0, 0, 0, 8'd0, 4'd0,  0, 0, 0, 4'd0);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      check_outs($sformatf("vec%0d", i), int'(tbl[i].en), int'(tbl[i].busy),
                 int'(tbl[i].done), int'(tbl[i].cnt));
      drive(tbl[i].rst, tbl[i].start, tbl[i].stop, tbl[i].mode, tbl[i].presc, tbl[i].len);
    end

    // Continuous, prescale 0, 20 enables, then stop: count wraps to 4.
    @(negedge clk); reset = 1'b1;
    @(negedge clk); drive(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 4'd0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      start = 1'b0;
      check("cont.enable", int'(enable), 1);
      check("cont.pulse_cnt", int'(pulse_cnt), i % 16);
      check("cont.downstream", int'(pulse_cnt), int'(down_q));
      if (i == 19) stop = 1'b1;
    end
    @(negedge clk);
    stop = 1'b0;
    check_outs("cont_stop", 0, 0, 0, 4);
    check("cont_stop.downstream", int'(down_q), 4);

    // Stop coincident with the 3rd enable of an 8-burst.
    @(negedge clk); drive(1'b0, 1'b1, 1'b0, 1'b1, 8'd0, 4'd8);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start = 1'b0;
      check_outs($sformatf("stop8.c%0d", i), 1, 1, 0, i);
      if (i == 2) stop = 1'b1;
    end
    @(negedge clk);
    stop = 1'b0;
    check_outs("stop8.after", 0, 0, 0, 3);
    @(negedge clk);
    check_outs("stop8.hold", 0, 0, 0, 3);

    // Reset mid-burst at pulse_cnt 2, prescale 4.
    @(negedge clk); drive(1'b0, 1'b1, 1'b0, 1'b1, 8'd4, 4'd8);
    for (int i = 0; i <= 10; i++) begin
      @(negedge clk);
      start = 1'b0;
      check($sformatf("rstmid.en%0d", i), int'(enable), (i % 5 == 4) ? 1 : 0);
      if (i == 10) begin
        check("rstmid.cnt_before", int'(pulse_cnt), 2);
        reset = 1'b1;
      end
    end
    @(negedge clk);
    reset = 1'b0;
    check_outs("rstmid.after", 0, 0, 0, 0);
    @(negedge clk);
    check_outs("rstmid.after2", 0, 0, 0, 0);

    // Randomized traffic against the reference model.
    @(negedge clk); drive(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 4'd0);
    @(negedge clk); reset = 1'b0;
    m_run = 0; m_t = 0; m_mode = 0; m_p = 0; m_len = 0; m_cnt = 0; m_done = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      exp_en = m_run && ((m_t % (m_p + 1)) == m_p);
      check_outs("rand", int'(exp_en), int'(m_run), int'(m_done), m_cnt);

      reset     = ($urandom_range(0, 149) == 0);
      start     = ($urandom_range(0, 3) == 0);
      stop      = ($urandom_range(0, 19) == 0);
      mode      = 1'($urandom_range(0, 1));
      prescale  = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 3));
      burst_len = 4'($urandom_range(0, 15));

      if (reset) begin
        m_run = 0; m_cnt = 0; m_done = 0;
      end else begin
        nd = 0;
        if (m_run) begin
          if (exp_en) begin
            m_cnt = (m_cnt + 1) % 16;
            if (m_mode && (m_cnt == m_len)) begin
              m_run = 0;
              nd = !stop;
            end
          end
          if (stop) m_run = 0;
          m_t++;
        end else if (start && !stop) begin
          m_cnt = 0;
          if (mode && (burst_len == 4'd0)) begin
            nd = 1;
          end else begin
            m_run = 1; m_t = 0; m_mode = mode; m_p = int'(prescale); m_len = int'(burst_len);
          end
        end
        m_done = nd;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
